// File: rtl/ext_pipe.sv
// ext_pipe: pipelined immediate / load-lane extension unit for the MIPS datapath.
// Extracts an immediate or a byte/halfword/word lane from a DATA_W-wide input,
// extends it, and carries the result through a STAGES-deep registered pipeline
// with stall, flush and misalignment reporting.
module ext_pipe #(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16,
  parameter int STAGES = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  input  logic [2:0]                    op,
  input  logic [$clog2(DATA_W/8)-1:0]   addr,
  input  logic [DATA_W-1:0]             in,
  input  logic                          stall,
  input  logic                          flush,
  output logic                          out_valid,
  output logic [DATA_W-1:0]             out,
  output logic                          misalign
);

  localparam int AW = $clog2(DATA_W/8);

  localparam logic [2:0] OP_SEXT = 3'b000;
  localparam logic [2:0] OP_ZEXT = 3'b001;
  localparam logic [2:0] OP_LUI  = 3'b010;
  localparam logic [2:0] OP_LB   = 3'b011;
  localparam logic [2:0] OP_LBU  = 3'b100;
  localparam logic [2:0] OP_LH   = 3'b101;
  localparam logic [2:0] OP_LHU  = 3'b110;
  localparam logic [2:0] OP_LW   = 3'b111;

  // Width class of the raw field: selects the sign bit and fill mask.
  localparam logic [2:0] W_BYTE = 3'd0;
  localparam logic [2:0] W_HALF = 3'd1;
  localparam logic [2:0] W_IMM  = 3'd2;
  localparam logic [2:0] W_LUI  = 3'd3;
  localparam logic [2:0] W_FULL = 3'd4;

  // Extend a zero-padded raw field according to its width class.
  function automatic logic [DATA_W-1:0] extend(input logic [DATA_W-1:0] raw,
                                               input logic [2:0]        wsel,
                                               input logic              sgn);
    logic [DATA_W-1:0] mask;
    logic              sbit;
    mask = '0;
    sbit = 1'b0;
    case (wsel)
      W_BYTE: begin mask[7:0]         = '1; sbit = raw[7];         end
      W_HALF: begin mask[15:0]        = '1; sbit = raw[15];        end
      W_IMM:  begin mask[IMM_W-1:0]   = '1; sbit = raw[IMM_W-1];   end
      W_LUI:  begin mask[2*IMM_W-1:0] = '1; sbit = raw[2*IMM_W-1]; end
      default: begin mask = '1; sbit = 1'b0; end
    endcase
    return (raw & mask) | ((sgn && sbit) ? ~mask : '0);
  endfunction

  logic [7:0]        byte_lane;
  logic [15:0]       half_lane;
  logic [DATA_W-1:0] x_raw;
  logic [2:0]        x_wsel;
  logic              x_sgn;
  logic              x_mis;

  assign byte_lane = 8'(in >> {addr, 3'b000});
  assign half_lane = 16'(in >> {addr[AW-1:1], 4'b0000});

  // Extract the raw field, width class, signedness and misalignment of the input beat.
  always_comb begin
    x_raw  = '0;
    x_wsel = W_FULL;
    x_sgn  = 1'b0;
    x_mis  = 1'b0;
    case (op)
      OP_SEXT: begin
        x_raw[IMM_W-1:0] = in[IMM_W-1:0];
        x_wsel = W_IMM;
        x_sgn  = 1'b1;
      end
      OP_ZEXT: begin
        x_raw[IMM_W-1:0] = in[IMM_W-1:0];
        x_wsel = W_IMM;
      end
      OP_LUI: begin
        x_raw[2*IMM_W-1:0] = {in[IMM_W-1:0], {IMM_W{1'b0}}};
        x_wsel = W_LUI;
        x_sgn  = 1'b1;
      end
      OP_LB, OP_LBU: begin
        x_raw[7:0] = byte_lane;
        x_wsel = W_BYTE;
        x_sgn  = (op == OP_LB);
      end
      OP_LH, OP_LHU: begin
        x_wsel = W_HALF;
        x_sgn  = (op == OP_LH);
        if (addr[0]) x_mis = 1'b1;
        else         x_raw[15:0] = half_lane;
      end
      default: begin
        x_wsel = W_FULL;
        if (addr != '0) x_mis = 1'b1;
        else            x_raw = in;
      end
    endcase
  end

  if (STAGES == 1) begin : g_one
    // Single stage: extract and extend in one cone into the output register.
    always_ff @(posedge clk) begin
      if (reset || flush) begin
        out_valid <= 1'b0;
        out       <= '0;
        misalign  <= 1'b0;
      end else if (!stall) begin
        out_valid <= in_valid;
        out       <= in_valid ? extend(x_raw, x_wsel, x_sgn) : '0;
        misalign  <= in_valid & x_mis;
      end
    end
  end else begin : g_two
    logic              s1_valid;
    logic [DATA_W-1:0] s1_raw;
    logic [2:0]        s1_wsel;
    logic              s1_sgn;
    logic              s1_mis;

    // Stage 1: register the extracted raw field, width class and misalign flag.
    always_ff @(posedge clk) begin
      if (reset || flush) begin
        s1_valid <= 1'b0;
        s1_raw   <= '0;
        s1_wsel  <= W_FULL;
        s1_sgn   <= 1'b0;
        s1_mis   <= 1'b0;
      end else if (!stall) begin
        s1_valid <= in_valid;
        s1_raw   <= in_valid ? x_raw : '0;
        s1_wsel  <= in_valid ? x_wsel : W_FULL;
        s1_sgn   <= in_valid & x_sgn;
        s1_mis   <= in_valid & x_mis;
      end
    end

    // Stage 2: register the extended result; an invalid stage 1 carries zeros.
    always_ff @(posedge clk) begin
      if (reset || flush) begin
        out_valid <= 1'b0;
        out       <= '0;
        misalign  <= 1'b0;
      end else if (!stall) begin
        out_valid <= s1_valid;
        out       <= extend(s1_raw, s1_wsel, s1_sgn);
        misalign  <= s1_mis;
      end
    end
  end

endmodule

// File: tb/tb_ext_pipe.sv
// Self-checking bench for ext_pipe: table-driven vectors for a 32-bit/2-stage
// instance and a 64-bit/1-stage instance, plus stall, flush and reset sequences.
module tb_ext_pipe;

  localparam logic [2:0] OP_SEXT = 3'b000;
  localparam logic [2:0] OP_ZEXT = 3'b001;
  localparam logic [2:0] OP_LUI  = 3'b010;
  localparam logic [2:0] OP_LB   = 3'b011;
  localparam logic [2:0] OP_LBU  = 3'b100;
  localparam logic [2:0] OP_LH   = 3'b101;
  localparam logic [2:0] OP_LHU  = 3'b110;
  localparam logic [2:0] OP_LW   = 3'b111;

  typedef struct {
    logic [2:0]  op;
    logic [2:0]  addr;
    logic [63:0] din;
    logic [63:0] exp;
    logic        mis;
  } vec_t;

  localparam int N32 = 15;
  localparam int N64 = 6;

  vec_t vecs32[N32];
  vec_t vecs64[N64];

  int n_cmp = 0;
  int n_mis = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 32-bit, 2-stage instance
  logic        a_reset, a_in_valid, a_stall, a_flush;
  logic [2:0]  a_op;
  logic [1:0]  a_addr;
  logic [31:0] a_in;
  logic        a_out_valid, a_misalign;
  logic [31:0] a_out;

  // 64-bit, 1-stage instance
  logic        b_reset, b_in_valid, b_stall, b_flush;
  logic [2:0]  b_op;
  logic [2:0]  b_addr;
  logic [63:0] b_in;
  logic        b_out_valid, b_misalign;
  logic [63:0] b_out;

  ext_pipe #(.DATA_W(32), .IMM_W(16), .STAGES(2)) dut_a (
    .clk(clk), .reset(a_reset), .in_valid(a_in_valid), .op(a_op), .addr(a_addr),
    .in(a_in), .stall(a_stall), .flush(a_flush), .out_valid(a_out_valid),
    .out(a_out), .misalign(a_misalign)
  );

  ext_pipe #(.DATA_W(64), .IMM_W(16), .STAGES(1)) dut_b (
    .clk(clk), .reset(b_reset), .in_valid(b_in_valid), .op(b_op), .addr(b_addr),
    .in(b_in), .stall(b_stall), .flush(b_flush), .out_valid(b_out_valid),
    .out(b_out), .misalign(b_misalign)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_a(input string name, input logic v, input logic [31:0] o, input logic m);
    check({name, ".valid"}, {63'd0, a_out_valid}, {63'd0, v});
    check({name, ".out"},   {32'd0, a_out},       {32'd0, o});
    check({name, ".mis"},   {63'd0, a_misalign},  {63'd0, m});
  endtask

  task automatic drive_a(input logic v, input logic [2:0] op, input logic [1:0] ad, input logic [31:0] d);
    a_in_valid = v;
    a_op       = op;
    a_addr     = ad;
    a_in       = d;
  endtask

  initial begin
    vecs32[0]  = '{OP_SEXT, 3'd0, 64'h0000_8001, 64'hFFFF_8001, 1'b0};
    vecs32[1]  = '{OP_ZEXT, 3'd0, 64'h0000_8001, 64'h0000_8001, 1'b0};
    vecs32[2]  = '{OP_LUI,  3'd0, 64'h0000_8001, 64'h8001_0000, 1'b0};
    vecs32[3]  = '{OP_LB,   3'd2, 64'h80FF_7F01, 64'hFFFF_FFFF, 1'b0};
    vecs32[4]  = '{OP_LBU,  3'd3, 64'h80FF_7F01, 64'h0000_0080, 1'b0};
    vecs32[5]  = '{OP_LB,   3'd1, 64'h80FF_7F01, 64'h0000_007F, 1'b0};
    vecs32[6]  = '{OP_LH,   3'd2, 64'h80FF_7F01, 64'hFFFF_80FF, 1'b0};
    vecs32[7]  = '{OP_LHU,  3'd0, 64'h80FF_7F01, 64'h0000_7F01, 1'b0};
    vecs32[8]  = '{OP_LW,   3'd0, 64'h80FF_7F01, 64'h80FF_7F01, 1'b0};
    vecs32[9]  = '{OP_LH,   3'd1, 64'h80FF_7F01, 64'h0000_0000, 1'b1};
    vecs32[10] = '{OP_LW,   3'd2, 64'h80FF_7F01, 64'h0000_0000, 1'b1};
    vecs32[11] = '{OP_LB,   3'd1, 64'h80FF_7F01, 64'h0000_007F, 1'b0};
    vecs32[12] = '{OP_SEXT, 3'd3, 64'hABCD_1234, 64'h0000_1234, 1'b0};
    vecs32[13] = '{OP_LHU,  3'd2, 64'h80FF_7F01, 64'h0000_80FF, 1'b0};
    vecs32[14] = '{OP_LUI,  3'd1, 64'hFFFF_7FFF, 64'h7FFF_0000, 1'b0};

    vecs64[0] = '{OP_LB,  3'd0, 64'h8000_0000_0000_00F0, 64'hFFFF_FFFF_FFFF_FFF0, 1'b0};
    vecs64[1] = '{OP_LW,  3'd0, 64'h8000_0000_0000_00F0, 64'h8000_0000_0000_00F0, 1'b0};
    vecs64[2] = '{OP_LUI, 3'd0, 64'h0000_0000_0000_8001, 64'hFFFF_FFFF_8001_0000, 1'b0};
    vecs64[3] = '{OP_LH,  3'd6, 64'h8000_0000_0000_00F0, 64'hFFFF_FFFF_FFFF_8000, 1'b0};
    vecs64[4] = '{OP_LHU, 3'd6, 64'h8000_0000_0000_00F0, 64'h0000_0000_0000_8000, 1'b0};
    vecs64[5] = '{OP_LW,  3'd4, 64'h8000_0000_0000_00F0, 64'h0000_0000_0000_0000, 1'b1};

    a_reset = 1'b1; a_stall = 1'b0; a_flush = 1'b0;
    drive_a(1'b1, OP_LW, 2'd0, 32'h1234_5678);
    b_reset = 1'b1; b_stall = 1'b0; b_flush = 1'b0;
    b_in_valid = 1'b1; b_op = OP_LW; b_addr = 3'd0; b_in = 64'h1111_2222_3333_4444;

    // Reset state
    step();
    check_a("reset_a", 1'b0, 32'h0, 1'b0);
    check("reset_b.valid", {63'd0, b_out_valid}, 64'd0);
    check("reset_b.out",   b_out, 64'd0);
    check("reset_b.mis",   {63'd0, b_misalign}, 64'd0);
    a_reset = 1'b0;
    b_reset = 1'b0;
    drive_a(1'b0, OP_SEXT, 2'd0, 32'h0);
    b_in_valid = 1'b0;
    step();
    check_a("idle_a", 1'b0, 32'h0, 1'b0);

    // Back-to-back table on the 2-stage instance: beat i shows after the edge accepting beat i+1
    for (int i = 0; i <= N32; i++) begin
      if (i < N32) drive_a(1'b1, vecs32[i].op, vecs32[i].addr[1:0], vecs32[i].din[31:0]);
      else         drive_a(1'b0, OP_SEXT, 2'd0, 32'h0);
      step();
      if (i >= 1)
        check_a($sformatf("vec32[%0d]", i - 1), 1'b1, vecs32[i-1].exp[31:0], vecs32[i-1].mis);
    end
    step();
    check_a("bubble_a", 1'b0, 32'h0, 1'b0);

    // Stall: A, B accepted, 3 stall cycles with garbage, then C
    drive_a(1'b1, OP_LBU, 2'd0, 32'h0000_0011);   // A
    step();
    check_a("stall.fill", 1'b0, 32'h0, 1'b0);
    drive_a(1'b1, OP_ZEXT, 2'd0, 32'h0000_2222);  // B
    step();
    check_a("stall.A", 1'b1, 32'h0000_0011, 1'b0);
    a_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive_a(1'b1, 3'(k), 2'(k + 1), 32'hDEAD_BEEF ^ 32'(k));
      step();
      check_a($sformatf("stall.hold%0d", k), 1'b1, 32'h0000_0011, 1'b0);
    end
    a_stall = 1'b0;
    drive_a(1'b1, OP_LW, 2'd0, 32'h3333_3333);    // C
    step();
    check_a("stall.B", 1'b1, 32'h0000_2222, 1'b0);
    drive_a(1'b0, OP_SEXT, 2'd0, 32'h0);
    step();
    check_a("stall.C", 1'b1, 32'h3333_3333, 1'b0);
    step();
    check_a("stall.drain", 1'b0, 32'h0, 1'b0);

    // Flush with stall: X in stage 1, Y presented at the flushing edge
    drive_a(1'b1, OP_LW, 2'd0, 32'hAAAA_AAAA);    // X
    step();
    drive_a(1'b1, OP_LW, 2'd0, 32'hBBBB_BBBB);    // Y
    a_flush = 1'b1;
    a_stall = 1'b1;
    step();
    check_a("flush.now", 1'b0, 32'h0, 1'b0);
    a_flush = 1'b0;
    a_stall = 1'b0;
    drive_a(1'b0, OP_SEXT, 2'd0, 32'h0);
    for (int k = 0; k < 2; k++) begin
      step();
      check_a($sformatf("flush.after%0d", k), 1'b0, 32'h0, 1'b0);
    end

    // Reset mid-stream with a misaligned beat at the output
    drive_a(1'b1, OP_LW, 2'd1, 32'hCCCC_CCCC);    // P, misaligned
    step();
    drive_a(1'b1, OP_LB, 2'd0, 32'h0000_0055);    // Q
    step();
    check_a("rst.P", 1'b1, 32'h0, 1'b1);
    drive_a(1'b1, OP_LW, 2'd0, 32'h7777_7777);    // R
    a_reset = 1'b1;
    step();
    check_a("rst.now", 1'b0, 32'h0, 1'b0);
    a_reset = 1'b0;
    drive_a(1'b0, OP_SEXT, 2'd0, 32'h0);
    step();
    check_a("rst.after", 1'b0, 32'h0, 1'b0);

    // 64-bit, 1-stage instance: result visible right after the accepting edge
    for (int i = 0; i < N64; i++) begin
      b_in_valid = 1'b1;
      b_op       = vecs64[i].op;
      b_addr     = vecs64[i].addr;
      b_in       = vecs64[i].din;
      step();
      check($sformatf("vec64[%0d].valid", i), {63'd0, b_out_valid}, 64'd1);
      check($sformatf("vec64[%0d].out", i),   b_out, vecs64[i].exp);
      check($sformatf("vec64[%0d].mis", i),   {63'd0, b_misalign}, {63'd0, vecs64[i].mis});
    end
    b_in_valid = 1'b0;
    step();
    check("bubble_b.valid", {63'd0, b_out_valid}, 64'd0);
    check("bubble_b.out",   b_out, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
